grayscale_frame_ctrl: RTL and testbench

- Sequences one frame of packed RGB pixels through the combinational grayscale datapath.
- Reads pixels from a 1-cycle-latency source RAM, registers them into the datapath inputs, and captures the datapath outputs into a 2-entry output buffer.
- Streams results out with valid/ready and a last flag; sits between the frame RAM and the output writer/DMA.

---
 rtl/grayscale_pkg.sv | 30 +++
 rtl/gs_out_buf.sv | 45 ++++
 rtl/grayscale_frame_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_grayscale_frame_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/grayscale_pkg.sv
// Shared types for the grayscale frame controller: pixel widths, FSM states
// and {R,G,B} pack/unpack helpers.
package grayscale_pkg;

    localparam int CH_W  = 8;
    localparam int PIX_W = 24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic [CH_W-1:0] r;
        logic [CH_W-1:0] g;
        logic [CH_W-1:0] b;
    } rgb_t;

    function automatic logic [PIX_W-1:0] pack_rgb(input logic [CH_W-1:0] r,
                                                  input logic [CH_W-1:0] g,
                                                  input logic [CH_W-1:0] b);
        return {r, g, b};
    endfunction

    function automatic rgb_t unpack_rgb(input logic [PIX_W-1:0] p);
        return rgb_t'(p);
    endfunction

endpackage

// File: rtl/gs_out_buf.sv
// Two-entry output FIFO with occupancy count; flush empties it in one cycle
// and takes priority over push/pop. The caller never pushes into a full buffer.
module gs_out_buf #(
    parameter int W = 25
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic [1:0]   count
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/grayscale_frame_ctrl.sv
// Streams one frame from a 1-cycle-latency RAM through an external grayscale
// datapath into a 2-entry output buffer; at most 3 pixels in flight.
module grayscale_frame_ctrl
    import grayscale_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int DIM_W     = 12,
    parameter int OUT_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [DIM_W-1:0]  cfg_width,
    input  logic [DIM_W-1:0]  cfg_height,
    input  logic              cfg_bypass,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [PIX_W-1:0]  mem_rd_data,
    output logic [CH_W-1:0]   gs_r_in,
    output logic [CH_W-1:0]   gs_g_in,
    output logic [CH_W-1:0]   gs_b_in,
    input  logic [CH_W-1:0]   gs_r_out,
    input  logic [CH_W-1:0]   gs_g_out,
    input  logic [CH_W-1:0]   gs_b_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PIX_W-1:0]  out_data,
    output logic              out_last
);

    localparam int               CNT_W        = 2 * DIM_W;
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [2:0]       MAX_INFLIGHT = 3'(OUT_DEPTH + 1);
    localparam logic [1:0]       BUF_FULL     = 2'(OUT_DEPTH);

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] base_q;
    logic [CNT_W-1:0]  last_idx;
    logic [CNT_W-1:0]  rd_cnt;
    logic [CNT_W-1:0]  wr_cnt;
    logic [CNT_W-1:0]  n_calc;
    logic              byp_q;
    logic              pend;
    logic              sta_v;
    rgb_t              sta;
    logic [1:0]        buf_cnt;
    logic [PIX_W:0]    buf_din;
    logic [PIX_W:0]    buf_dout;
    logic [2:0]        occ;
    logic              pop;
    logic              room;
    logic              push;
    logic              issue;
    logic              start_ok;
    logic              start_bad;

    assign out_valid = (buf_cnt != 2'd0);
    assign pop       = out_valid & out_ready;

    // Occupancy counts the read returning this cycle, stage A and the buffer
    // after this cycle's pop; capping it keeps stage A always free for data.
    assign occ   = {2'b00, pend} + {2'b00, sta_v} + {1'b0, buf_cnt} - {2'b00, pop};
    assign room  = (buf_cnt - {1'b0, pop}) < BUF_FULL;
    assign push  = sta_v & room;
    assign issue = (state == RUN) && !abort && (occ < MAX_INFLIGHT);

    assign n_calc    = {{DIM_W{1'b0}}, cfg_width} * {{DIM_W{1'b0}}, cfg_height};
    assign start_ok  = (state == IDLE) && start && !abort &&
                       (cfg_width != '0) && (cfg_height != '0);
    assign start_bad = (state == IDLE) && start && !abort &&
                       ((cfg_width == '0) || (cfg_height == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (abort) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:    if (start_ok) state_nx = RUN;
                RUN:     if (issue && (rd_cnt == last_idx)) state_nx = DRAIN;
                DRAIN:   if (pop && out_last) state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        busy        = (state != IDLE);
        mem_rd_en   = issue;
        mem_rd_addr = '0;
        if (issue) begin
            mem_rd_addr = base_q + ADDR_W'(rd_cnt);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q   <= '0;
            last_idx <= '0;
            byp_q    <= 1'b0;
            rd_cnt   <= '0;
            wr_cnt   <= '0;
        end else if (start_ok) begin
            base_q   <= cfg_base;
            last_idx <= n_calc - CNT_ONE;
            byp_q    <= cfg_bypass;
            rd_cnt   <= '0;
            wr_cnt   <= '0;
        end else begin
            if (issue) rd_cnt <= rd_cnt + CNT_ONE;
            if (push)  wr_cnt <= wr_cnt + CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend  <= 1'b0;
            sta_v <= 1'b0;
            sta   <= '0;
        end else if (abort) begin
            pend  <= 1'b0;
            sta_v <= 1'b0;
        end else begin
            pend <= issue;
            if (pend) begin
                sta   <= unpack_rgb(mem_rd_data);
                sta_v <= 1'b1;
            end else if (push) begin
                sta_v <= 1'b0;
            end
        end
    end

    assign gs_r_in = sta.r;
    assign gs_g_in = sta.g;
    assign gs_b_in = sta.b;

    assign buf_din = {(wr_cnt == last_idx),
                      byp_q ? pack_rgb(sta.r, sta.g, sta.b)
                            : pack_rgb(gs_r_out, gs_g_out, gs_b_out)};

    gs_out_buf #(
        .W(PIX_W + 1)
    ) u_out_buf (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .pop  (pop),
        .flush(abort),
        .din  (buf_din),
        .dout (buf_dout),
        .count(buf_cnt)
    );

    assign out_data = buf_dout[PIX_W-1:0];
    assign out_last = buf_dout[PIX_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done <= 1'b0;
            err  <= 1'b0;
        end else begin
            done <= (state == DRAIN) && pop && out_last && !abort;
            err  <= start_bad;
        end
    end

endmodule

// File: tb/tb_grayscale_frame_ctrl.sv
// Randomized bench for grayscale_frame_ctrl with a queue-based frame model.
module tb_grayscale_frame_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] cfg_base = '0;
    logic [11:0] cfg_width = '0;
    logic [11:0] cfg_height = '0;
    logic        cfg_bypass = 1'b0;
    logic        busy, done, err, mem_rd_en;
    logic [15:0] mem_rd_addr;
    logic [23:0] mem_rd_data = '0;
    logic [7:0]  gs_r_in, gs_g_in, gs_b_in;
    logic [7:0]  gs_r_out, gs_g_out, gs_b_out;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [23:0] out_data;
    logic        out_last;

    grayscale_frame_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_base(cfg_base), .cfg_width(cfg_width), .cfg_height(cfg_height),
        .cfg_bypass(cfg_bypass), .busy(busy), .done(done), .err(err),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .gs_r_in(gs_r_in), .gs_g_in(gs_g_in), .gs_b_in(gs_b_in),
        .gs_r_out(gs_r_out), .gs_g_out(gs_g_out), .gs_b_out(gs_b_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] gray(input logic [23:0] p);
        int s;
        logic [7:0] y;
        s = 77 * int'(p[23:16]) + 150 * int'(p[15:8]) + 29 * int'(p[7:0]);
        y = 8'(s >> 8);
        return {y, y, y};
    endfunction

    // Environment: frame RAM and the external combinational grayscale datapath.
    logic [23:0] ram [0:65535];
    always @(posedge clk) if (mem_rd_en) mem_rd_data <= ram[mem_rd_addr];
    always_comb {gs_r_out, gs_g_out, gs_b_out} = gray({gs_r_in, gs_g_in, gs_b_in});

    typedef struct packed { logic [23:0] d; logic l; } exp_t;
    exp_t        exp_q[$];
    logic [15:0] addr_q[$];
    logic [15:0] obs_addr[$];
    logic [23:0] obs_pix[$];
    int          total = 0, bad = 0;
    int          issued = 0, accepted = 0, done_cnt = 0;
    logic        exp_done = 1'b0, stalled = 1'b0;
    logic [24:0] held = '0;
    int          rdy_mode = 0, rdy_ph = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete(); addr_q.delete();
            stalled = 1'b0; exp_done = 1'b0; issued = 0; accepted = 0;
        end else if (abort) begin
            exp_q.delete(); addr_q.delete();
            stalled = 1'b0; exp_done = 1'b0; accepted = issued;
        end else begin
            chk("done", done, exp_done);
            if (done) done_cnt++;
            exp_done = 1'b0;
            if (stalled) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_hold", {out_last, out_data}, held);
            end
            if (out_valid) begin
                if (exp_q.size() == 0) chk("extra_out", out_valid, 0);
                else begin
                    chk("out_data", out_data, exp_q[0].d);
                    chk("out_last", out_last, exp_q[0].l);
                    if (out_ready) begin
                        if (exp_q[0].l) exp_done = 1'b1;
                        obs_pix.push_back(out_data);
                        void'(exp_q.pop_front());
                        accepted++;
                    end
                end
            end
            stalled = out_valid && !out_ready;
            held = {out_last, out_data};
            if (mem_rd_en) begin
                obs_addr.push_back(mem_rd_addr);
                issued++;
                if (addr_q.size() == 0) chk("extra_rd", mem_rd_en, 0);
                else chk("rd_addr", mem_rd_addr, addr_q.pop_front());
                chk("inflight_le3", (issued - accepted) <= 3, 1);
            end
        end
    end

    initial forever begin
        @(posedge clk); #1;
        case (rdy_mode)
            1:       begin out_ready = (rdy_ph % 3 == 0); rdy_ph++; end
            2:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b1;
        endcase
    end

    task automatic load_frame(input logic [15:0] base, input int w, input int h, input logic byp);
        for (int i = 0; i < w * h; i++) begin
            logic [15:0] a;
            exp_t e;
            a = base + 16'(i);
            addr_q.push_back(a);
            e.d = byp ? ram[a] : gray(ram[a]);
            e.l = (i == w * h - 1);
            exp_q.push_back(e);
        end
        obs_addr.delete(); obs_pix.delete();
    endtask

    task automatic set_cfg(input logic [15:0] base, input int w, input int h, input logic byp);
        cfg_base = base; cfg_width = 12'(w); cfg_height = 12'(h); cfg_bypass = byp;
    endtask

    task automatic kick();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        {cfg_base, cfg_width, cfg_height, cfg_bypass} = 41'({$urandom, $urandom});
    endtask

    task automatic wait_done(input int d0, input int limit);
        int k = 0;
        while (done_cnt == d0 && k < limit) begin @(posedge clk); k++; end
        #1;
        chk("done_seen", done_cnt - d0, 1);
        chk("left_pix", exp_q.size(), 0);
        chk("left_rd", addr_q.size(), 0);
    endtask

    task automatic run_frame(input logic [15:0] base, input int w, input int h,
                             input logic byp, input int mode, input logic poke);
        int d0;
        rdy_mode = mode;
        load_frame(base, w, h, byp);
        set_cfg(base, w, h, byp);
        d0 = done_cnt;
        kick();
        if (poke) begin
            set_cfg(16'($urandom), 3, 3, 1'b0);
            start = 1'b1; @(posedge clk); #1; start = 1'b0;
        end
        wait_done(d0, 100 + w * h * 8);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done_err"}, {done, err}, 0);
        chk({tag, "_rd"}, {mem_rd_en, mem_rd_addr}, 0);
        chk({tag, "_gs_in"}, {gs_r_in, gs_g_in, gs_b_in}, 0);
        chk({tag, "_out"}, {out_valid, out_last, out_data}, 0);
    endtask

    initial begin
        logic [23:0] lit [4];
        logic [15:0] wad [4];
        logic        r_en [10], r_v [10], r_d [10];
        logic [15:0] r_a [10];
        int          d0;

        for (int i = 0; i < 65536; i++) ram[i] = 24'($urandom);
        repeat (3) @(posedge clk);
        #1 chk_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        lit[0] = 24'h4C4C4C; lit[1] = 24'h959595; lit[2] = 24'h1C1C1C; lit[3] = 24'h808080;
        chk("model_r", gray(24'hFF0000), lit[0]);
        chk("model_g", gray(24'h00FF00), lit[1]);
        chk("model_b", gray(24'h0000FF), lit[2]);
        chk("model_mid", gray(24'h808080), lit[3]);
        ram[16'h10] = 24'hFF0000; ram[16'h11] = 24'h00FF00;
        ram[16'h12] = 24'h0000FF; ram[16'h13] = 24'h808080;

        // 2x2 frame: cycle-accurate timeline from the start-sampling cycle.
        rdy_mode = 0;
        load_frame(16'h0010, 2, 2, 1'b0);
        set_cfg(16'h0010, 2, 2, 1'b0);
        start = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            r_en[c] = mem_rd_en; r_a[c] = mem_rd_addr; r_v[c] = out_valid; r_d[c] = done;
            @(posedge clk); #1;
            if (c == 0) start = 1'b0;
        end
        for (int c = 0; c < 10; c++) begin
            chk($sformatf("t_rd_en%0d", c), r_en[c], (c >= 1 && c <= 4));
            if (c >= 1 && c <= 4) chk($sformatf("t_addr%0d", c), r_a[c], 16'h0010 + 16'(c - 1));
            chk($sformatf("t_valid%0d", c), r_v[c], (c >= 4 && c <= 7));
            chk($sformatf("t_done%0d", c), r_d[c], (c == 8));
        end
        chk("t_npix", obs_pix.size(), 4);
        for (int i = 0; i < obs_pix.size() && i < 4; i++) chk($sformatf("t_pix%0d", i), obs_pix[i], lit[i]);

        // Same frame under 1,0,0 backpressure.
        run_frame(16'h0010, 2, 2, 1'b0, 1, 1'b0);
        chk("bp_npix", obs_pix.size(), 4);
        for (int i = 0; i < obs_pix.size() && i < 4; i++) chk($sformatf("bp_pix%0d", i), obs_pix[i], lit[i]);

        // Zero dimension: err pulse only.
        rdy_mode = 0;
        set_cfg(16'h0100, 0, 5, 1'b0);
        start = 1'b1;
        @(negedge clk); chk("err_c0", err, 0);
        @(posedge clk); #1; start = 1'b0;
        for (int c = 1; c < 6; c++) begin
            @(negedge clk);
            chk($sformatf("err_c%0d", c), err, (c == 1));
            chk($sformatf("err_rd%0d", c), mem_rd_en, 0);
            chk($sformatf("err_busy%0d", c), busy, 0);
            @(posedge clk); #1;
        end

        // Bypass 1x3.
        lit[0] = 24'h123456; lit[1] = 24'hABCDEF; lit[2] = 24'h000001;
        ram[16'h0200] = lit[0]; ram[16'h0201] = lit[1]; ram[16'h0202] = lit[2];
        run_frame(16'h0200, 1, 3, 1'b1, 2, 1'b0);
        chk("byp_npix", obs_pix.size(), 3);
        for (int i = 0; i < obs_pix.size() && i < 3; i++) chk($sformatf("byp_pix%0d", i), obs_pix[i], lit[i]);

        // Address wrap.
        wad[0] = 16'hFFFE; wad[1] = 16'hFFFF; wad[2] = 16'h0000; wad[3] = 16'h0001;
        run_frame(16'hFFFE, 1, 4, 1'b0, 0, 1'b0);
        chk("wrap_nrd", obs_addr.size(), 4);
        for (int i = 0; i < obs_addr.size() && i < 4; i++) chk($sformatf("wrap_a%0d", i), obs_addr[i], wad[i]);

        // Abort in cycle 5 of an 8x8 frame, then a 1x1 frame.
        rdy_mode = 0;
        load_frame(16'h0400, 8, 8, 1'b0);
        set_cfg(16'h0400, 8, 8, 1'b0);
        d0 = done_cnt;
        kick();
        repeat (4) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        chk("abort_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        repeat (10) @(posedge clk);
        #1 chk("abort_no_done", done_cnt - d0, 0);
        run_frame(16'h0500, 1, 1, 1'b0, 0, 1'b0);

        // Randomized frames with config changes and start pokes while busy.
        for (int k = 0; k < 12; k++)
            run_frame(16'($urandom), $urandom_range(1, 6), $urandom_range(1, 6),
                      1'($urandom), $urandom_range(0, 2), 1'(k % 2));

        // Reset mid-frame, then recovery.
        rdy_mode = 2;
        load_frame(16'h0600, 3, 3, 1'b0);
        set_cfg(16'h0600, 3, 3, 1'b0);
        kick();
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1 chk_zero("midrst");
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        run_frame(16'h0700, 3, 2, 1'b0, 2, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
